// File: rtl/ram_tdp_clr.sv
// True dual-port RAM with post-reset self-clear sequencer and write-collision flag.
// Optional: define RAM_CROSS_BYPASS_EN to forward cross-port write data to the other port's read.
module ram_tdp_clr #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a1,
  input  logic [DATA_W-1:0] d1,
  input  logic              we1,
  output logic [DATA_W-1:0] q1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [DATA_W-1:0] d2,
  input  logic              we2,
  output logic [DATA_W-1:0] q2,
  output logic              busy,
  output logic              coll
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** (ADDR_W - 1)) - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] q1_q, q1_d, q2_q, q2_d;
  logic              coll_q, coll_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wen1, wen2;
  logic [ADDR_W-1:0] wa1, wa2;
  logic [DATA_W-1:0] wd1, wd2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              same_addr, collide;

  assign rd1       = mem[a1];
  assign rd2       = mem[a2];
  assign same_addr = (a1 == a2);
  assign collide   = we1 && we2 && same_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q1_d    = '0;
    q2_d    = '0;
    coll_d  = 1'b0;
    wen1    = 1'b0;
    wen2    = 1'b0;
    wa1     = a1;
    wa2     = a2;
    wd1     = d1;
    wd2     = d2;
    case (state_q)
      ST_CLEAR: begin
        // Two words per cycle: even address on port 1, odd on port 2.
        wen1 = 1'b1;
        wen2 = 1'b1;
        wa1  = ADDR_W'({cnt_q, 1'b0});
        wa2  = ADDR_W'({cnt_q, 1'b1});
        wd1  = '0;
        wd2  = '0;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        wen1   = we1;
        wen2   = we2 && !collide;
        coll_d = collide;
        if (we1) begin
          q1_d = d1;
        end else if (we2 && same_addr) begin
`ifdef RAM_CROSS_BYPASS_EN
          q1_d = d2;
`else
          q1_d = rd1;
`endif
        end else begin
          q1_d = rd1;
        end
        // Port 1 wins a collision, so port 2 also sees d1 then.
        if (collide) begin
          q2_d = d1;
        end else if (we2) begin
          q2_d = d2;
        end else if (we1 && same_addr) begin
`ifdef RAM_CROSS_BYPASS_EN
          q2_d = d1;
`else
          q2_d = rd2;
`endif
        end else begin
          q2_d = rd2;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      coll_q  <= coll_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wen2) mem[wa2] <= wd2;
    if (wen1) mem[wa1] <= wd1;
  end

  assign q1   = q1_q;
  assign q2   = q2_q;
  assign coll = coll_q;
  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_tdp_clr.sv
// Bench for ram_tdp_clr: vector table plus clear/reset sequences, default and 16x16 instances.
module tb_ram_tdp_clr;

`ifdef RAM_CROSS_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [6:0] a1, a2;
  logic [7:0] d1, d2, q1, q2;
  logic       we1, we2, busy, coll;

  logic [3:0]  s_a1, s_a2;
  logic [15:0] s_d1, s_d2, s_q1, s_q2;
  logic        s_we1, s_we2, s_busy, s_coll;

  ram_tdp_clr dut (
    .clk(clk), .rst_n(rst_n),
    .a1(a1), .d1(d1), .we1(we1), .q1(q1),
    .a2(a2), .d2(d2), .we2(we2), .q2(q2),
    .busy(busy), .coll(coll)
  );

  ram_tdp_clr #(.DATA_W(16), .ADDR_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .a1(s_a1), .d1(s_d1), .we1(s_we1), .q1(s_q1),
    .a2(s_a2), .d2(s_d2), .we2(s_we2), .q2(s_q2),
    .busy(s_busy), .coll(s_coll)
  );

  typedef struct {
    logic       we1;
    logic [6:0] a1;
    logic [7:0] d1;
    logic       we2;
    logic [6:0] a2;
    logic [7:0] d2;
    logic [7:0] eq1;
    logic [7:0] eq2;
    logic       ecoll;
  } vec_t;

  typedef struct {
    logic [7:0] q1;
    logic [7:0] q2;
    logic       coll;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    we1 = v.we1; a1 = v.a1; d1 = v.d1;
    we2 = v.we2; a2 = v.a2; d2 = v.d2;
    sb.push_back('{v.eq1, v.eq2, v.ecoll});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".q1"},   16'(q1),   16'(e.q1));
    chk({tag, ".q2"},   16'(q2),   16'(e.q2));
    chk({tag, ".coll"}, 16'(coll), 16'(e.coll));
  endtask

  // Counts edges from reset release until busy drops; also records the small instance.
  task automatic count_busy(output int n, output int ns);
    n  = 0;
    ns = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (!s_busy && ns == 0) ns = i;
      if (!busy) begin
        n = i;
        break;
      end
      chk("clear.q1", 16'(q1), 16'h0);
      chk("clear.q2", 16'(q2), 16'h0);
      chk("clear.coll", 16'(coll), 16'h0);
    end
  endtask

  initial begin
    int   n, ns;
    vec_t v;

    vecs[0]  = '{1'b0, 7'h79, 8'h00, 1'b0, 7'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 7'h05, 8'h00, 1'b0, 7'h06, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 7'h79, 8'hCC, 1'b1, 7'h78, 8'hCD, 8'hCC, 8'hCD, 1'b0};
    vecs[3]  = '{1'b0, 7'h79, 8'h00, 1'b0, 7'h78, 8'h00, 8'hCC, 8'hCD, 1'b0};
    vecs[4]  = '{1'b1, 7'h7F, 8'hF0, 1'b1, 7'h7E, 8'hF1, 8'hF0, 8'hF1, 1'b0};
    vecs[5]  = '{1'b0, 7'h7F, 8'h00, 1'b0, 7'h7E, 8'h00, 8'hF0, 8'hF1, 1'b0};
    vecs[6]  = '{1'b1, 7'h10, 8'hAA, 1'b1, 7'h10, 8'h55, 8'hAA, 8'hAA, 1'b1};
    vecs[7]  = '{1'b0, 7'h10, 8'h00, 1'b0, 7'h10, 8'h00, 8'hAA, 8'hAA, 1'b0};
    vecs[8]  = '{1'b1, 7'h20, 8'h11, 1'b0, 7'h00, 8'h00, 8'h11, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 7'h20, 8'h22, 1'b0, 7'h20, 8'h00, 8'h22,
                 (BYP ? 8'h22 : 8'h11), 1'b0};
    vecs[10] = '{1'b0, 7'h20, 8'h00, 1'b0, 7'h20, 8'h00, 8'h22, 8'h22, 1'b0};
    vecs[11] = '{1'b0, 7'h20, 8'h00, 1'b1, 7'h20, 8'h33,
                 (BYP ? 8'h33 : 8'h22), 8'h33, 1'b0};
    vecs[12] = '{1'b0, 7'h55, 8'h00, 1'b0, 7'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 7'h79, 8'h00, 1'b0, 7'h7E, 8'h00, 8'hCC, 8'hF1, 1'b0};

    rst_n = 1'b0;
    we1 = 1'b0; a1 = '0; d1 = '0;
    we2 = 1'b0; a2 = '0; d2 = '0;
    s_we1 = 1'b0; s_a1 = '0; s_d1 = '0;
    s_we2 = 1'b0; s_a2 = '0; s_d2 = '0;
    #12;
    chk("rst.busy", 16'(busy), 16'h1);
    chk("rst.q1", 16'(q1), 16'h0);
    chk("rst.q2", 16'(q2), 16'h0);
    chk("rst.coll", 16'(coll), 16'h0);
    chk("rst.s_busy", 16'(s_busy), 16'h1);

    // User writes attempted during the clear must be dropped.
    @(negedge clk);
    rst_n = 1'b1;
    we1 = 1'b1; a1 = 7'h05; d1 = 8'hFF;
    we2 = 1'b1; a2 = 7'h06; d2 = 8'hEE;
    count_busy(n, ns);
    chk("busy_len", 16'(n), 16'd64);
    chk("s_busy_len", 16'(ns), 16'd8);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Small instance: write via port 2, read back via port 1.
    we1 = 1'b0; we2 = 1'b0;
    s_we2 = 1'b1; s_a2 = 4'h3; s_d2 = 16'hBEEF; s_a1 = 4'h2;
    @(posedge clk);
    #1;
    chk("s.q2_wr", s_q2, 16'hBEEF);
    chk("s.q1_clr", s_q1, 16'h0000);
    s_we2 = 1'b0; s_a1 = 4'h3;
    @(posedge clk);
    #1;
    chk("s.q1_rd", s_q1, 16'hBEEF);

    // Reset in RUN must restart the clear from address 0.
    v = '{1'b1, 7'h40, 8'h3C, 1'b0, 7'h41, 8'h00, 8'h3C, 8'h00, 1'b0};
    apply(v, "mid.wr");
    v = '{1'b0, 7'h40, 8'h00, 1'b0, 7'h7F, 8'h00, 8'h3C, 8'hF0, 1'b0};
    apply(v, "mid.rd");
    rst_n = 1'b0;
    #2;
    chk("mid.rst.q1", 16'(q1), 16'h0);
    chk("mid.rst.q2", 16'(q2), 16'h0);
    chk("mid.rst.busy", 16'(busy), 16'h1);
    chk("mid.rst.s_q1", s_q1, 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we1 = 1'b0; we2 = 1'b0;
    count_busy(n, ns);
    chk("busy_len2", 16'(n), 16'd64);
    chk("s_busy_len2", 16'(ns), 16'd8);
    v = '{1'b0, 7'h40, 8'h00, 1'b0, 7'h7F, 8'h00, 8'h00, 8'h00, 1'b0};
    apply(v, "post.rd");
    s_a1 = 4'h3;
    @(posedge clk);
    #1;
    chk("s.post_clr", s_q1, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_tdp_clr.md
# ram_tdp_clr

Parametrised true dual-port synchronous RAM with two independent read/write ports, a self-clearing sequencer that zeroes the whole array after every reset, and write-collision detection. It generalises the team's fixed 8-bit × 128-entry dual-port RAM in data width and depth, and adds reset, busy and collision status. It serves as the shared buffer between two producer/consumer datapaths on one clock.

## Interface
- DATA_W, 8, data width of each port
- ADDR_W, 7, address width; depth = 2^ADDR_W (ADDR_W ≥ 1)

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a1  in  ADDR_W  port-1 address
- d1  in  DATA_W  port-1 write data
- we1  in  1  port-1 write enable
- q1  out  DATA_W  port-1 registered read data
- a2  in  ADDR_W  port-2 address
- d2  in  DATA_W  port-2 write data
- we2  in  1  port-2 write enable
- q2  out  DATA_W  port-2 registered read data
- busy  out  1  high while clear sequence runs; user accesses ignored
- coll  out  1  one-cycle pulse: both ports wrote same address in same cycle

## Operation
- One clock; reset is asynchronous and active-low.
- FSM states: CLEAR, RUN.
- rst_n low: state ← CLEAR, clear counter ← 0, q1 = q2 = 0, busy = 1, coll = 0. Array contents are not reset asynchronously.
- CLEAR: each cycle writes 0 to addresses 2·cnt (via port 1) and 2·cnt+1 (via port 2); cnt increments. After the cycle with cnt = 2^(ADDR_W−1)−1, state ← RUN, busy ← 0. The clear takes 2^(ADDR_W−1) cycles (64 at defaults).
- During CLEAR: we1/we2/a1/a2/d1/d2 are ignored, q1/q2 hold 0, coll stays 0.
- RUN, per port p: if wep, mem[ap] ← dp. qp ← read of mem[ap] each cycle, whether or not the port is writing.
- Same-port read-during-write: write-first, so qp returns dp.
- Cross-port (port p reads the address port o writes in the same cycle): read-first by default, so qp returns the old contents. See Configuration.
- Write collision (we1 & we2 & a1 == a2): port 1 wins, mem ← d1. q1 = q2 = d1. coll = 1 in the next cycle only.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to CLEAR; the clear sequence restarts from address 0.

## Timing
- Read latency: 1 cycle. qp is valid after the rising edge that samples ap.
- Write takes effect at the sampling edge and is visible to a read at the next edge.
- busy deasserts on the edge that completes the final clear write. The first user access is sampled on the following edge.
- coll is registered; it is high for exactly the cycle after the colliding edge.
- After rst_n deasserts, busy = 1 for exactly 2^(ADDR_W−1) rising edges.

## Configuration
- RAM_CROSS_BYPASS_EN defined: a cross-port read of an address the other port writes in the same cycle returns the new write data (on collision, d1).
- RAM_CROSS_BYPASS_EN undefined: such a read returns the old memory contents (read-first).
- Same-port write-first behaviour and collision priority are identical in both builds.

## Test plan
- Reset/clear: pulse rst_n low, release. Expect busy = 1 for 64 cycles, then 0. Reading a1 = 7'h79 and a2 = 7'h00 returns 8'h00 on both.
- Basic dual write/read: we1 = we2 = 1, a1 = 7'h79, d1 = 8'hCC, a2 = 7'h78, d2 = 8'hCD. Next cycle drop the write enables. Expect q1 = 8'hCC and q2 = 8'hCD one cycle later. Repeat at 7'h7F/7'h7E with 8'hF0/8'hF1.
- Collision: we1 = we2 = 1, a1 = a2 = 7'h10, d1 = 8'hAA, d2 = 8'h55. Expect coll = 1 for one cycle; a subsequent read of 7'h10 returns 8'hAA.
- Cross-port: mem[7'h20] = 8'h11. Port 1 writes 8'h22 to 7'h20 while port 2 reads 7'h20. Expect q2 = 8'h11 without RAM_CROSS_BYPASS_EN and 8'h22 with it.
- Accesses during busy: assert we1 = 1, a1 = 7'h05, d1 = 8'hFF during CLEAR. After busy falls, reading 7'h05 returns 8'h00.
- Reset mid-operation: write 8'h3C to 7'h40, assert rst_n low for 1 cycle in RUN. Expect q1 = q2 = 0 immediately, busy = 1 for 64 cycles, then reading 7'h40 returns 8'h00. Rerun at DATA_W = 16, ADDR_W = 4: busy lasts 8 cycles.
